// File: rtl/reg_resp_if.sv
// Request/response channel between a register initiator and the reg_resp register file.
// The master modport is the initiator side; the slave modport is the responder side.
interface reg_resp_if #(
   parameter int WIDTH = 8,
   parameter int AW    = 32
);
   logic             req_valid;
   logic             req_ready;
   logic             req_wr;
   logic [AW-1:0]    addr;
   logic [WIDTH-1:0] wdata;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] data;
   logic             rsp_err;

   modport master (
      output req_valid, req_wr, addr, wdata, rsp_ready,
      input  req_ready, rsp_valid, data, rsp_err
   );

   modport slave (
      input  req_valid, req_wr, addr, wdata, rsp_ready,
      output req_ready, rsp_valid, data, rsp_err
   );
endinterface

// File: rtl/reg_resp.sv
// Register-file responder: DEPTH x WIDTH registers behind a valid/ready request channel,
// with one response per request returned in order through a 2-entry response FIFO.
module reg_resp #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   reg_resp_if.slave   bus,
   output logic [7:0]  err_cnt
);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] regs      [DEPTH];
   logic [WIDTH-1:0] fifo_data [2];
   logic             fifo_err  [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;

   logic             push;
   logic             pop;
   logic             in_range;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] rsp_data_in;
   logic             rsp_err_in;

   // rst_n is active-high despite its name; both channels are held idle while it is asserted.
   assign bus.req_ready = (count != 2'd2) & ~rst_n;
   assign bus.rsp_valid = (count != 2'd0) & ~rst_n;
   assign bus.data      = bus.rsp_valid ? fifo_data[rd_ptr] : '0;
   assign bus.rsp_err   = bus.rsp_valid ? fifo_err[rd_ptr]  : 1'b0;

   assign push     = bus.req_valid & bus.req_ready;
   assign pop      = bus.rsp_valid & bus.rsp_ready;
   assign in_range = (bus.addr < AW'(DEPTH));
   assign idx      = bus.addr[IW-1:0];

   // Reads return the register contents from before this edge's write.
   always_comb begin
      rsp_data_in = '0;
      rsp_err_in  = 1'b1;
      if (in_range) begin
         rsp_err_in  = 1'b0;
         rsp_data_in = bus.req_wr ? bus.wdata : regs[idx];
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (push && in_range && bus.req_wr) begin
         regs[idx] <= bus.wdata;
      end
   end

   // Simultaneous push and pop leaves the occupancy unchanged while the head moves on.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         count        <= 2'd0;
         wr_ptr       <= 1'b0;
         rd_ptr       <= 1'b0;
         fifo_data[0] <= '0;
         fifo_data[1] <= '0;
         fifo_err[0]  <= 1'b0;
         fifo_err[1]  <= 1'b0;
      end else begin
         if (push) begin
            fifo_data[wr_ptr] <= rsp_data_in;
            fifo_err[wr_ptr]  <= rsp_err_in;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         err_cnt <= 8'd0;
      end else if (push && !in_range && (err_cnt != 8'hFF)) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end
endmodule

// File: doc/reg_resp.md
Name: reg_resp

Overview:
- Register-file responder: the target end of the addr/data register interface that REG_MODULE-style initiators drive.
- Accepts read/write requests on a valid/ready request channel and holds DEPTH registers of WIDTH bits.
- Returns one response per request on a valid/ready response channel, buffered in a 2-entry response FIFO.
- Sits beside initiator blocks in generated top-levels, on the shared clk.

Parameters:
WIDTH  8   register/data width in bits (>=1)
DEPTH  16  number of registers; valid addresses 0..DEPTH-1
AW     32  request address width

Ports:
clk        input   1      system clock, all logic on rising edge
rst_n      input   1      reset; synchronous, active-high (asserted = 1), despite the name
req_valid  input   1      request present
req_ready  output  1      responder can accept a request
req_wr     input   1      1 = write, 0 = read
addr       input   AW     request register address
wdata      input   WIDTH  write data
rsp_valid  output  1      response present
rsp_ready  input   1      downstream accepts response
data       output  WIDTH  response data
rsp_err    output  1      response flags an out-of-range address
err_cnt    output  8      count of erroring requests, saturating

Behaviour:
- Clocking and reset: one clock (clk). Reset rst_n is synchronous, active-high.
- While rst_n=1 at a clk edge:
  - all DEPTH registers clear to 0
  - FIFO clears: count=0, pointers=0
  - err_cnt=0
- Outputs during and after reset:
  - rsp_valid=0, data=0, rsp_err=0
  - req_ready=0 while rst_n=1
- Reset mid-transaction drops every buffered response with no partial output.
- Handshakes:
  - Request accepted on an edge where req_valid & req_ready.
  - Response popped on an edge where rsp_valid & rsp_ready.
  - req_ready = (count != 2) & ~rst_n. It has no combinational path from rsp_ready.
  - While rsp_valid=1 and rsp_ready=0, data and rsp_err hold stable.
- Request processing, at the acceptance edge:
  - in-range = addr < DEPTH, compared over the full AW bits.
  - Write in range: reg[addr] <= wdata. Response data=wdata, err=0.
  - Read in range: response data = reg[addr] as stored before this edge, err=0.
  - Out of range, read or write: no register change. Response data=0, err=1. err_cnt increments, saturating at 255.
- Latency: the response is pushed at the acceptance edge, so rsp_valid is 1 in the next cycle. Request-to-response latency is 1 cycle when the FIFO is empty.
- FIFO:
  - 2 entries of {err, data}; data/rsp_err driven from the head entry; rsp_valid = (count != 0).
  - Push only: count+1. Pop only: count-1.
  - Push and pop on the same edge: count unchanged, head advances.
  - Push with count=2 is impossible because req_ready=0.
  - Pointers are 1 bit and wrap 1->0.
  - With count=0, data=0 and rsp_err=0.
- Back-to-back ordering: write A on cycle n, read A on cycle n+1 returns the new value. Responses are returned strictly in request order.
- Throughput: 1 request/cycle while rsp_ready=1 continuously.

Test Plan:
- Reset: hold rst_n=1 for 3 cycles with req_valid=1. Required: req_ready=0, rsp_valid=0, err_cnt=0. Read of addr 5 after release returns data=0x00, err=0.
- Write/read: write addr 3 = 0xA5, then read addr 3 on the next cycle, rsp_ready=1. Required: two responses on consecutive cycles: 0xA5/err0 (echo), then 0xA5/err0. Each arrives 1 cycle after its acceptance.
- Backpressure: rsp_ready=0, issue reads of addr 1 and 2 (preloaded 0x11, 0x22). Required:
  - req_ready drops to 0 after the 2nd accept; head holds 0x11 stable for 5 cycles.
  - Raise rsp_ready: 0x11 then 0x22 pop in order, and req_ready returns to 1 after the first pop.
- Out of range: write addr 16 = 0xFF, then read addr 0x80000000. Required: both responses data=0, err=1. err_cnt=2; all registers unchanged.
- Saturation and simultaneity: 300 out-of-range requests with rsp_ready=1 and continuous push+pop. Required: count never exceeds 1, err_cnt=255, one response per cycle.
- Mid-operation reset: with FIFO full, assert rst_n=1 for 1 cycle. Required: next cycle rsp_valid=0, req_ready=1, and a read of the previously written address returns 0.
